// File: rtl/rtc_bus_secuenciador.sv
// rtc_bus_secuenciador
// Sequences a single RTC register access over the multiplexed 8-bit
// address/data bus: address phase, bus turnaround, then a write or read data
// phase. The strobes and the bus-driver controls are all registered.
//
// Ports:
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   start              access request, sampled in IDLE
//   lectura            1 = read, 0 = write (latched with start)
//   direccion          register address    (latched with start)
//   dato_esc           write data          (latched with start)
//   dato_bus_in        byte returned by the bus driver
//   flag_escritura     driver drive-enable
//   flag_lectura       driver read flag
//   dato_bus_out       byte presented to the driver
//   cs_n/ad_n/wr_n/rd_n RTC strobes, active low
//   dato_leido         last captured read byte
//   busy               high in every state except IDLE
//   done               one-cycle pulse in FIN
//   pendiente          (SEC_PENDIENTE_EN only) one request is queued
//
// Optional feature macro: SEC_PENDIENTE_EN adds a one-deep pending request.
module rtc_bus_secuenciador #(
  parameter int unsigned T_SU   = 2,
  parameter int unsigned T_PW   = 4,
  parameter int unsigned T_H    = 2,
  parameter int unsigned T_TURN = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       lectura,
  input  logic [7:0] direccion,
  input  logic [7:0] dato_esc,
  input  logic [7:0] dato_bus_in,
  output logic       flag_escritura,
  output logic       flag_lectura,
  output logic [7:0] dato_bus_out,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] dato_leido,
  output logic       busy,
  output logic       done
`ifdef SEC_PENDIENTE_EN
  ,
  output logic       pendiente
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_A_SU, S_A_PW, S_A_H, S_TURN, S_D_SU, S_D_PW, S_D_H, S_FIN
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       lat_rd, rd_nxt;
  logic [7:0] lat_dir, dir_nxt, lat_dat, dat_nxt;
  logic       launch;
  logic       nx_addr, nx_data;

  function automatic logic [7:0] dur(input state_t s);
    case (s)
      S_A_SU, S_D_SU: dur = 8'(T_SU - 1);
      S_A_PW, S_D_PW: dur = 8'(T_PW - 1);
      S_A_H,  S_D_H:  dur = 8'(T_H - 1);
      S_TURN:         dur = 8'(T_TURN - 1);
      default:        dur = '0;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      S_A_SU:  succ = S_A_PW;
      S_A_PW:  succ = S_A_H;
      S_A_H:   succ = S_TURN;
      S_TURN:  succ = S_D_SU;
      S_D_SU:  succ = S_D_PW;
      S_D_PW:  succ = S_D_H;
      S_D_H:   succ = S_FIN;
      default: succ = S_IDLE;
    endcase
  endfunction

`ifdef SEC_PENDIENTE_EN
  logic       pend_rd;
  logic [7:0] pend_dir, pend_dat;

  assign launch = start || pendiente;

  // A queued request is launched from IDLE in preference to a new start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pendiente <= 1'b0;
      pend_rd   <= 1'b0;
      pend_dir  <= '0;
      pend_dat  <= '0;
    end else if (state == S_IDLE) begin
      pendiente <= 1'b0;
    end else if (start && !pendiente) begin
      pendiente <= 1'b1;
      pend_rd   <= lectura;
      pend_dir  <= direccion;
      pend_dat  <= dato_esc;
    end
  end
`else
  assign launch = start;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = lat_rd;
    dir_nxt   = lat_dir;
    dat_nxt   = lat_dat;
    if (state == S_IDLE) begin
      if (launch) begin
        state_nxt = S_A_SU;
        cnt_nxt   = dur(S_A_SU);
`ifdef SEC_PENDIENTE_EN
        if (pendiente) begin
          rd_nxt  = pend_rd;
          dir_nxt = pend_dir;
          dat_nxt = pend_dat;
        end else begin
          rd_nxt  = lectura;
          dir_nxt = direccion;
          dat_nxt = dato_esc;
        end
`else
        rd_nxt  = lectura;
        dir_nxt = direccion;
        dat_nxt = dato_esc;
`endif
      end
    end else if (cnt == '0) begin
      state_nxt = succ(state);
      cnt_nxt   = dur(state_nxt);
    end else begin
      cnt_nxt = cnt - 8'd1;
    end
  end

  assign nx_addr = (state_nxt == S_A_SU) || (state_nxt == S_A_PW) || (state_nxt == S_A_H);
  assign nx_data = (state_nxt == S_D_SU) || (state_nxt == S_D_PW) || (state_nxt == S_D_H);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      lat_rd         <= 1'b0;
      lat_dir        <= '0;
      lat_dat        <= '0;
      cs_n           <= 1'b1;
      ad_n           <= 1'b1;
      wr_n           <= 1'b1;
      rd_n           <= 1'b1;
      flag_escritura <= 1'b0;
      flag_lectura   <= 1'b0;
      dato_bus_out   <= '0;
      dato_leido     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      lat_rd         <= rd_nxt;
      lat_dir        <= dir_nxt;
      lat_dat        <= dat_nxt;
      cs_n           <= !(nx_addr || nx_data || (state_nxt == S_TURN));
      ad_n           <= !nx_addr;
      wr_n           <= !((state_nxt == S_A_PW) || ((state_nxt == S_D_PW) && !rd_nxt));
      rd_n           <= !((state_nxt == S_D_PW) && rd_nxt);
      flag_escritura <= nx_addr || (nx_data && !rd_nxt);
      flag_lectura   <= rd_nxt && ((state_nxt == S_D_SU) || (state_nxt == S_D_PW));
      dato_bus_out   <= nx_addr ? dir_nxt : ((nx_data && !rd_nxt) ? dat_nxt : '0);
      busy           <= (state_nxt != S_IDLE);
      done           <= (state_nxt == S_FIN);
      // Capture on the last D_PW cycle, while rd_n is still low.
      if ((state == S_D_PW) && (cnt == '0) && lat_rd)
        dato_leido <= dato_bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_secuenciador.sv
// Testbench for rtc_bus_secuenciador: directed and randomized accesses checked
// cycle by cycle against a timeline model of the bus protocol.
module tb_rtc_bus_secuenciador;

  localparam int T_SU   = 2;
  localparam int T_PW   = 4;
  localparam int T_H    = 2;
  localparam int T_TURN = 2;
  localparam int A_LEN  = T_SU + T_PW + T_H;
  localparam int D0     = A_LEN + T_TURN;
  localparam int BUSY   = 2 * A_LEN + T_TURN + 1;
  localparam int DPW_FIRST = D0 + T_SU + 1;
  localparam int DPW_LAST  = D0 + T_SU + T_PW;

  logic       clk, reset_n, start, lectura;
  logic [7:0] direccion, dato_esc, dato_bus_in;
  logic       flag_escritura, flag_lectura, cs_n, ad_n, wr_n, rd_n, busy, done;
  logic [7:0] dato_bus_out, dato_leido;
`ifdef SEC_PENDIENTE_EN
  logic       pendiente;
`endif

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  exp_leido = '0;
  logic        exp_pend  = 1'b0;
  logic [15:0] obs_vec;

  rtc_bus_secuenciador #(.T_SU(T_SU), .T_PW(T_PW), .T_H(T_H), .T_TURN(T_TURN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .lectura(lectura),
    .direccion(direccion), .dato_esc(dato_esc), .dato_bus_in(dato_bus_in),
    .flag_escritura(flag_escritura), .flag_lectura(flag_lectura),
    .dato_bus_out(dato_bus_out), .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n),
    .rd_n(rd_n), .dato_leido(dato_leido), .busy(busy), .done(done)
`ifdef SEC_PENDIENTE_EN
    , .pendiente(pendiente)
`endif
  );

  assign obs_vec = {cs_n, ad_n, wr_n, rd_n, flag_escritura, flag_lectura, busy, done, dato_bus_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected outputs k cycles after acceptance (k=0 or k>BUSY means idle).
  // Packing: {cs_n, ad_n, wr_n, rd_n, flag_esc, flag_lec, busy, done, bus[7:0]}.
  function automatic logic [15:0] exp_vec(input int k, input logic rd,
                                          input logic [7:0] dir, input logic [7:0] dat);
    logic cs = 1'b1, ad = 1'b1, wr = 1'b1, rn = 1'b1, fe = 1'b0, fl = 1'b0, bz = 1'b0, dn = 1'b0;
    logic [7:0] b = '0;
    int j;
    if (k >= 1 && k <= A_LEN) begin
      cs = 1'b0; ad = 1'b0; fe = 1'b1; b = dir;
      if (k > T_SU && k <= T_SU + T_PW) wr = 1'b0;
    end else if (k > A_LEN && k <= D0) begin
      cs = 1'b0;
    end else if (k > D0 && k <= D0 + A_LEN) begin
      j  = k - D0;
      cs = 1'b0;
      if (rd) begin
        fl = (j <= T_SU + T_PW);
        if (j > T_SU && j <= T_SU + T_PW) rn = 1'b0;
      end else begin
        fe = 1'b1; b = dat;
        if (j > T_SU && j <= T_SU + T_PW) wr = 1'b0;
      end
    end
    if (k >= 1 && k <= BUSY) bz = 1'b1;
    if (k == BUSY) dn = 1'b1;
    return {cs, ad, wr, rn, fe, fl, bz, dn, b};
  endfunction

  // One access. Called #1 after a rising edge with the DUT in IDLE (or with a
  // queued request when nostart is set). intr/intr2: cycles at which a start
  // with different values is pulsed while busy. hold keeps start high.
  task automatic run_access(input logic rd, input logic [7:0] dir, input logic [7:0] dat,
                            input logic [7:0] rdata, input bit hold, input int intr,
                            input int intr2, input bit nostart);
    int busy_n = 0;
    int done_n = 0;
    int pset   = -1;
    if (!nostart) begin
      start = 1'b1; lectura = rd; direccion = dir; dato_esc = dat;
    end else begin
      start = 1'b0;
    end
    for (int k = 1; k <= BUSY + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) exp_pend = 1'b0;
      if (k == pset) exp_pend = 1'b1;
      if (rd && k == DPW_LAST + 1) exp_leido = rdata;
      chk($sformatf("out k=%0d", k), 32'(obs_vec), 32'(exp_vec(k <= BUSY ? k : 0, rd, dir, dat)));
      chk($sformatf("leido k=%0d", k), 32'(dato_leido), 32'(exp_leido));
      chk("inv_flags", 32'(flag_escritura & flag_lectura), 32'(0));
      chk("inv_wr_rd", 32'(!wr_n && !rd_n), 32'(0));
`ifdef SEC_PENDIENTE_EN
      chk($sformatf("pend k=%0d", k), 32'(pendiente), 32'(exp_pend));
`endif
      busy_n += int'(busy);
      done_n += int'(done);
      start = hold || (k == intr) || (k == intr2);
      if (k == intr) begin
        lectura = ~rd; direccion = ~dir; dato_esc = ~dat;
        if (!exp_pend && k <= BUSY) pset = k + 1;
      end else if (k == intr2) begin
        lectura = rd; direccion = dir ^ 8'h5A; dato_esc = dat ^ 8'hA5;
      end else begin
        lectura = 1'($urandom_range(0, 1)); direccion = 8'($urandom); dato_esc = 8'($urandom);
      end
      if (k >= DPW_FIRST && k <= DPW_LAST)
        dato_bus_in = (k == DPW_LAST) ? rdata : ~rdata;
      else
        dato_bus_in = 8'($urandom);
    end
    chk("busy_cycles", 32'(busy_n), 32'(BUSY));
    chk("done_pulses", 32'(done_n), 32'(1));
  endtask

  initial begin
    logic       r_rd;
    logic [7:0] r_dir, r_dat, r_rdata;
    bit         r_hold;
    int         r_intr;

    reset_n = 1'b1; start = 1'b0; lectura = 1'b0;
    direccion = '0; dato_esc = '0; dato_bus_in = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_vec", 32'(obs_vec), 32'(exp_vec(0, 1'b0, 8'h00, 8'h00)));
    chk("reset_leido", 32'(dato_leido), 32'(0));
`ifdef SEC_PENDIENTE_EN
    chk("reset_pend", 32'(pendiente), 32'(0));
`endif
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Write with defaults, then a read, then a write that must not disturb dato_leido.
    run_access(1'b0, 8'h23, 8'h45, 8'h00, 1'b0, 0, 0, 1'b0);
    run_access(1'b1, 8'h21, 8'h00, 8'h59, 1'b0, 0, 0, 1'b0);
    run_access(1'b0, 8'h30, 8'hA5, 8'h00, 1'b0, 0, 0, 1'b0);

`ifndef SEC_PENDIENTE_EN
    // start while busy is ignored; start held through FIN chains a new access.
    run_access(1'b0, 8'h12, 8'h34, 8'h00, 1'b0, 5, 0, 1'b0);
    run_access(1'b0, 8'h40, 8'h41, 8'h00, 1'b1, 0, 0, 1'b0);
    run_access(1'b1, 8'h42, 8'h00, 8'h77, 1'b0, 0, 0, 1'b0);
`endif

    // Reset in the middle of the write-data strobe.
    start = 1'b1; lectura = 1'b0; direccion = 8'h11; dato_esc = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (DPW_FIRST - 1) @(posedge clk);
    #1;
    chk("pre_reset_wr", 32'(wr_n), 32'(0));
    reset_n = 1'b0;
    #1;
    exp_leido = '0;
    exp_pend  = 1'b0;
    chk("async_reset_vec", 32'(obs_vec), 32'(exp_vec(0, 1'b0, 8'h00, 8'h00)));
    chk("async_reset_leido", 32'(dato_leido), 32'(0));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset c=%0d", c), 32'(obs_vec), 32'(exp_vec(0, 1'b0, 8'h00, 8'h00)));
      chk("post_reset_leido", 32'(dato_leido), 32'(0));
    end

    // Randomized accesses.
    for (int n = 0; n < 50; n++) begin
      r_rd    = 1'($urandom_range(0, 1));
      r_dir   = 8'($urandom);
      r_dat   = 8'($urandom);
      r_rdata = 8'($urandom);
`ifdef SEC_PENDIENTE_EN
      r_hold = 1'b0;
      r_intr = 0;
`else
      r_hold = (n < 49) && ($urandom_range(0, 3) == 0);
      r_intr = $urandom_range(0, BUSY);
`endif
      run_access(r_rd, r_dir, r_dat, r_rdata, r_hold, r_intr, 0, 1'b0);
    end

`ifdef SEC_PENDIENTE_EN
    // Second start is queued, third is dropped; queued access starts 2 cycles after done.
    run_access(1'b0, 8'h23, 8'h45, 8'h00, 1'b0, 3, 8, 1'b0);
    run_access(1'b1, 8'hDC, 8'hBA, 8'h6E, 1'b0, 0, 0, 1'b1);
    @(posedge clk); #1;
    chk("pend_final_idle", 32'(obs_vec), 32'(exp_vec(0, 1'b0, 8'h00, 8'h00)));
    chk("pend_final_flag", 32'(pendiente), 32'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_secuenciador.md
Name: rtc_bus_secuenciador

Overview:
Sequences one RTC register access over the multiplexed 8-bit address/data bus, which has a two-phase protocol. The bus is driven through the existing tri-state bidirectional bus driver. The block generates the strobes cs_n, ad_n, wr_n and rd_n. It also produces the driver's write/read flags and output byte, and captures the read byte. It sits between the register-bank/control FSM and the bus driver.

Parameters:
T_SU, 2, setup cycles before each strobe pulse (1..255)
T_PW, 4, strobe low width in cycles (1..255)
T_H, 2, hold cycles after each strobe pulse (1..255)
T_TURN, 2, bus-released cycles between address and data phases (1..255)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
lectura  in  1  1 = read access, 0 = write access; latched with start
direccion  in  8  RTC register address; latched with start
dato_esc  in  8  write data; latched with start
dato_bus_in  in  8  byte returned by the bus driver (its out_dato)
flag_escritura  out  1  driver drive-enable (write flag)
flag_lectura  out  1  driver read flag
dato_bus_out  out  8  byte to the driver (its in_dato)
cs_n, ad_n, wr_n, rd_n  out  1 each  RTC strobes, active low
dato_leido  out  8  last captured read byte
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate):
  - cs_n = ad_n = wr_n = rd_n = 1.
  - flag_escritura = flag_lectura = 0.
  - dato_bus_out = 0, dato_leido = 0, busy = 0, done = 0.
  - State is IDLE.
  - An access in progress is abandoned and has no later side effect.
- All outputs are registered.
- States, each lasting its parameter in cycles, with an 8-bit down-counter reloaded on each state entry:
  IDLE -> A_SU(T_SU) -> A_PW(T_PW) -> A_H(T_H) -> TURN(T_TURN) -> D_SU(T_SU) -> D_PW(T_PW) -> D_H(T_H) -> FIN(1) -> IDLE.
- Acceptance: start=1 in IDLE latches lectura, direccion and dato_esc. A_SU begins the next cycle.
  - Busy duration = 2*(T_SU+T_PW+T_H)+T_TURN+1 cycles; the defaults give 19.
- Address phase (A_SU, A_PW, A_H):
  - ad_n = 0, cs_n = 0, flag_escritura = 1, dato_bus_out = direccion.
  - wr_n = 0 only in A_PW.
- TURN:
  - cs_n = 0, ad_n = 1, both flags 0, dato_bus_out = 0.
  - The bus is released by both sides.
- Data phase, write (D_SU, D_PW, D_H):
  - cs_n = 0, flag_escritura = 1, dato_bus_out = dato_esc.
  - wr_n = 0 only in D_PW.
- Data phase, read (D_SU, D_PW, D_H):
  - cs_n = 0, flag_lectura = 1 in D_SU and D_PW, rd_n = 0 only in D_PW.
  - dato_leido <= dato_bus_in on the last D_PW cycle, while rd_n is still 0.
  - D_H has flag_lectura = 0.
- FIN: all strobes high, both flags 0, done = 1, busy = 1. IDLE follows with busy = 0.
- Invariants:
  - flag_escritura and flag_lectura are never 1 together.
  - wr_n and rd_n are never 0 together.
  - Neither strobe is 0 outside a PW state.
- dato_leido holds its value through writes and until the next read capture.
- start while busy is ignored: no queueing and no effect on latched values.
- start held high through FIN starts a new access on the IDLE cycle that follows FIN.
- Changes on direccion, dato_esc or lectura after acceptance have no effect.

Optional Feature:
SEC_PENDIENTE_EN
- Defined:
  - A one-deep pending register is added, with an extra output pendiente (1 bit), reset to 0.
  - start while busy with pendiente = 0 latches the request and sets pendiente.
  - After FIN, the pending request is launched at once; IDLE lasts 1 cycle, then A_SU begins and pendiente clears.
  - start while pendiente = 1 is dropped.
  - Reset clears the pending register.
- Undefined: no pending register and no pendiente port; start while busy is ignored.

Test Plan:
1. Write, defaults: start, lectura=0, direccion=0x23, dato_esc=0x45.
   - Busy for 19 cycles.
   - wr_n low 4 cycles with bus=0x23 and ad_n=0.
   - After 2 turn cycles, wr_n low 4 cycles with bus=0x45 and ad_n=1.
   - done is a single pulse.
2. Read: direccion=0x21, bench drives dato_bus_in=0x59 during D_PW.
   - rd_n low 4 cycles, flag_lectura high 6 cycles.
   - dato_leido=0x59 after capture.
   - dato_leido is unchanged by a following write.
3. start pulsed 5 cycles into an access with different direccion/dato: ignored; the original values appear on the bus and exactly one done is produced.
4. reset_n low during D_PW of a write: strobes go high and flags go 0 immediately. After release the block is IDLE, dato_leido=0, and no done appears.
5. Continuous protocol checks over 50 random accesses:
   - flags never both 1; wr_n and rd_n never both 0.
   - both flags 0 throughout TURN.
6. With SEC_PENDIENTE_EN defined: a second start during busy sets pendiente. The second access begins 2 cycles after the first done; a third start during busy is dropped.
